led_sequence_controller: RTL and testbench

- Playback sequencer that drives the 12 keypad LED code slots consumed by the LED decoder.
- The puzzle front end loads a pattern of up to 12 key codes (1..12) through a valid/ready port.
- On start, the block reveals the pattern one key per timer tick, holds the full pattern for a fixed number of ticks, then blanks all LEDs and pulses done.
- It is the only writer of the slot codes.

---
 rtl/led_sequence_controller.sv | 148 ++++++++++++++
 tb/tb_led_sequence_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/led_sequence_controller.sv
// rtl/led_sequence_controller.sv - keypad LED pattern loader and timed playback sequencer
// Optional macro LED_HOLD_BLINK_EN: blink the complete pattern during HOLD.
module led_sequence_controller #(
  parameter int TICK_DIV   = 25000000,
  parameter int HOLD_TICKS = 4
) (
  input  logic        CLOCK_50,
  input  logic        Reset,
  input  logic        load_valid,
  input  logic [3:0]  load_code,
  output logic        load_ready,
  input  logic        start,
  input  logic        abort,
  input  logic        clear_pat,
  output logic        busy,
  output logic        done,
  output logic        bad_code,
  output logic [3:0]  pat_len,
  output logic [47:0] slot_codes
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  typedef enum logic [1:0] {IDLE, SHOW, HOLD} state_t;

  state_t          state, state_nx;
  logic [3:0]      pattern [12];
  logic [PW-1:0]   presc;
  logic [3:0]      idx;
  logic [HW-1:0]   hold_cnt;
  logic            tick, xfer, code_ok, do_start, do_clear, last_step, hold_last;

`ifdef LED_HOLD_BLINK_EN
  logic            blank_phase;
  logic [47:0]     full_img;

  always_comb begin
    full_img = '0;
    for (int i = 0; i < 12; i++) begin
      if (4'(i) < pat_len) full_img[4*i +: 4] = pattern[i];
    end
  end
`endif

  // Gated by Reset so the port reads 0 while reset is held.
  assign load_ready = Reset && (state == IDLE) && (pat_len < 4'd12);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx  = state;
    tick      = (presc == PW'(TICK_DIV - 1));
    xfer      = load_valid && load_ready;
    code_ok   = (load_code != 4'd0) && (load_code <= 4'd12);
    do_start  = (state == IDLE) && start && (pat_len != 4'd0);
    do_clear  = (state == IDLE) && clear_pat && !do_start;
    last_step = (idx == pat_len - 4'd1);
    hold_last = (hold_cnt == HW'(HOLD_TICKS - 1));
    case (state)
      IDLE:    if (do_start) state_nx = SHOW;
      SHOW:    if (abort) state_nx = IDLE;
               else if (tick && last_step) state_nx = HOLD;
      HOLD:    if (abort) state_nx = IDLE;
               else if (tick && hold_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      presc      <= '0;
      idx        <= '0;
      hold_cnt   <= '0;
      pat_len    <= '0;
      slot_codes <= '0;
      done       <= 1'b0;
      bad_code   <= 1'b0;
      for (int i = 0; i < 12; i++) pattern[i] <= '0;
`ifdef LED_HOLD_BLINK_EN
      blank_phase <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      done     <= 1'b0;
      bad_code <= 1'b0;

      // Clear beats a same-cycle load; the offered entry is simply dropped.
      if (do_clear) begin
        pat_len <= '0;
      end else if (xfer) begin
        if (code_ok) begin
          pattern[pat_len] <= load_code;
          pat_len          <= pat_len + 4'd1;
        end else begin
          bad_code <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (do_start) begin
            idx   <= '0;
            presc <= '0;
          end
        end
        SHOW: begin
          if (abort) begin
            slot_codes <= '0;
          end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
              slot_codes[{idx, 2'b00} +: 4] <= pattern[idx];
              idx <= idx + 4'd1;
              if (last_step) begin
                hold_cnt <= '0;
`ifdef LED_HOLD_BLINK_EN
                blank_phase <= 1'b0;
`endif
              end
            end
          end
        end
        HOLD: begin
          if (abort) begin
            slot_codes <= '0;
          end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
              if (hold_last) begin
                slot_codes <= '0;
                done       <= 1'b1;
              end else begin
                hold_cnt <= hold_cnt + HW'(1);
`ifdef LED_HOLD_BLINK_EN
                slot_codes  <= blank_phase ? full_img : 48'd0;
                blank_phase <= ~blank_phase;
`endif
              end
            end
          end
        end
        default: slot_codes <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_sequence_controller.sv
// tb/tb_led_sequence_controller.sv - self-checking bench for led_sequence_controller
module tb_led_sequence_controller;

  localparam int T = 4;
  localparam int H = 2;

  logic        CLOCK_50 = 1'b0;
  logic        Reset;
  logic        load_valid, start, abort, clear_pat;
  logic [3:0]  load_code;
  logic        load_ready, busy, done, bad_code;
  logic [3:0]  pat_len;
  logic [47:0] slot_codes;

  int compared   = 0;
  int mismatched = 0;

  logic [3:0] model_pat [12];
  int         model_len = 0;

  led_sequence_controller #(.TICK_DIV(T), .HOLD_TICKS(H)) dut (
    .CLOCK_50  (CLOCK_50),
    .Reset     (Reset),
    .load_valid(load_valid),
    .load_code (load_code),
    .load_ready(load_ready),
    .start     (start),
    .abort     (abort),
    .clear_pat (clear_pat),
    .busy      (busy),
    .done      (done),
    .bad_code  (bad_code),
    .pat_len   (pat_len),
    .slot_codes(slot_codes)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected LEDs c cycles after the start edge: n ticks elapsed, n slots revealed.
  function automatic logic [47:0] exp_slots(input int c);
    int n, k;
    logic [47:0] img;
    n   = c / T;
    img = '0;
    if (n >= model_len + H) return '0;
    k = (n < model_len) ? n : model_len;
    for (int i = 0; i < k; i++) img[4*i +: 4] = model_pat[i];
`ifdef LED_HOLD_BLINK_EN
    if (n > model_len && ((n - model_len) % 2 == 1)) img = '0;
`endif
    return img;
  endfunction

  task automatic load(input logic [3:0] c);
    logic ok, take;
    ok   = (c >= 4'd1) && (c <= 4'd12);
    take = (model_len < 12);
    load_valid = 1'b1;
    load_code  = c;
    chk("load_ready", load_ready, take);
    tick;
    load_valid = 1'b0;
    if (take && ok) begin
      model_pat[model_len] = c;
      model_len++;
    end
    chk("bad_code", bad_code, take && !ok);
    chk("pat_len_load", pat_len, model_len);
  endtask

  task automatic do_clear;
    clear_pat = 1'b1;
    tick;
    clear_pat = 1'b0;
    model_len = 0;
    chk("pat_len_clear", pat_len, 0);
  endtask

  task automatic play(input int abort_at, input int reset_at, input logic with_clear);
    int total;
    total     = (model_len + H) * T;
    start     = 1'b1;
    clear_pat = with_clear;
    tick;
    start     = 1'b0;
    clear_pat = 1'b0;
    for (int c = 0; c <= total; c++) begin
      chk("slots", slot_codes, exp_slots(c));
      chk("done", done, c == total);
      chk("busy", busy, c < total);
      if (c == reset_at) begin
        Reset = 1'b0;
        #1;
        chk("rst_slots", slot_codes, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", load_ready, 0);
        chk("rst_len", pat_len, 0);
        model_len = 0;
        @(negedge CLOCK_50);
        Reset = 1'b1;
        tick;
        chk("post_rst_ready", load_ready, 1);
        chk("post_rst_len", pat_len, 0);
        return;
      end
      if (c == total) break;
      if (c + 1 == abort_at) begin
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_slots", slot_codes, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        return;
      end
      tick;
    end
    chk("play_len", pat_len, model_len);
    tick;
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    Reset = 1'b0; load_valid = 1'b0; load_code = '0;
    start = 1'b0; abort = 1'b0; clear_pat = 1'b0;
    #12;
    chk("reset_ready", load_ready, 0);
    chk("reset_len", pat_len, 0);
    chk("reset_slots", slot_codes, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_bad", bad_code, 0);
    @(negedge CLOCK_50);
    Reset = 1'b1;
    tick;
    chk("ready_after_reset", load_ready, 1);

    load(4'd5); load(4'd9); load(4'd1);
    play(-1, -1, 1'b0);

    do_clear;
    for (int i = 0; i < 12; i++) load(4'($urandom_range(1, 12)));
    load(4'd7);
    play(-1, -1, 1'b0);

    clear_pat = 1'b1; load_valid = 1'b1; load_code = 4'd5;
    tick;
    clear_pat = 1'b0; load_valid = 1'b0;
    model_len = 0;
    chk("clear_wins_len", pat_len, 0);
    chk("clear_wins_bad", bad_code, 0);
    load(4'd0);
    load(4'd15);

    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      chk("empty_busy", busy, 0);
      chk("empty_slots", slot_codes, 0);
      tick;
    end

    load(4'd3); load(4'd3); load(4'd7);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("idle_abort_len", pat_len, 3);
    play(9, -1, 1'b0);
    chk("abort_keeps_len", pat_len, 3);
    play(-1, -1, 1'b1);

    do_clear;
    load(4'd4); load(4'd8);
    play(-1, -1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int n;
      do_clear;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) load(4'($urandom_range(0, 15)));
      if (model_len > 0) play(-1, -1, 1'b0);
    end

    do_clear;
    load(4'd2); load(4'd11); load(4'd6);
    play(-1, 10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
